// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: shifts a WIDTH-bit word out on B one bit per clock,
// then holds B low for GAP idle cycles before the next word slot.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Din,
  input  logic             Load,
  input  logic             Abort,
  output logic             Ready,
  output logic             B,
  output logic             Bit_Vld,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_r, state_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [CW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [3:0]       gap_cnt_r, gap_cnt_s;
  logic             b_r, b_s;
  logic             bit_vld_r, bit_vld_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             ready_r, ready_s;
  logic             accept_s;

  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) begin
      return word[WIDTH-1];
    end else begin
      return word[0];
    end
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) begin
      return {word[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, word[WIDTH-1:1]};
    end
  endfunction

  // Ready is only ever high in IDLE or the final slot cycle, so an accept always starts a word.
  assign accept_s = Load & ready_r & ~Abort;

  // Next-state and next-output computation for the slot sequencer.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    gap_cnt_s = gap_cnt_r;
    b_s       = 1'b0;
    bit_vld_s = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    ready_s   = 1'b0;
    if (accept_s) begin
      state_s   = ST_SHIFT;
      shift_s   = shift_out(Din);
      b_s       = first_bit(Din);
      bit_cnt_s = '0;
      gap_cnt_s = 4'd0;
      bit_vld_s = 1'b1;
      busy_s    = 1'b1;
    end else if (Abort && busy_r) begin
      state_s   = ST_IDLE;
      shift_s   = '0;
      bit_cnt_s = '0;
      gap_cnt_s = 4'd0;
      ready_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_s = 1'b1;
        end
        ST_SHIFT: begin
          if (bit_cnt_r != LAST_BIT) begin
            shift_s   = shift_out(shift_r);
            b_s       = first_bit(shift_r);
            bit_cnt_s = bit_cnt_r + CNT_ONE;
            bit_vld_s = 1'b1;
            busy_s    = 1'b1;
            done_s    = (bit_cnt_r == PRE_LAST);
            ready_s   = (GAP == 32'd0) && (bit_cnt_r == PRE_LAST);
          end else if (GAP == 32'd0) begin
            state_s = ST_IDLE;
            ready_s = 1'b1;
          end else begin
            state_s   = ST_GAP;
            gap_cnt_s = 4'd0;
            busy_s    = 1'b1;
            ready_s   = (GAP == 32'd1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_r != GAP_LAST) begin
            gap_cnt_s = gap_cnt_r + 4'd1;
            busy_s    = 1'b1;
            ready_s   = ((gap_cnt_r + 4'd1) == GAP_LAST);
          end else begin
            state_s = ST_IDLE;
            ready_s = 1'b1;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          shift_s   = '0;
          bit_cnt_s = '0;
          gap_cnt_s = 4'd0;
          ready_s   = 1'b1;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      gap_cnt_r <= 4'd0;
      b_r       <= 1'b0;
      bit_vld_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      b_r       <= b_s;
      bit_vld_r <= bit_vld_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      ready_r   <= ready_s;
    end
  end

  assign Ready   = ready_r;
  assign B       = b_r;
  assign Bit_Vld = bit_vld_r;
  assign Busy    = busy_r;
  assign Done    = done_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (MSB/GAP=1, LSB/GAP=1, MSB/GAP=0) checked
// against a slot-position reference model, a vector table and directed corner sequences.
module tb_bit_serializer;

  localparam int W = 8;
  localparam int MF [3] = '{1, 0, 1};
  localparam int GP [3] = '{1, 1, 0};

  logic       Clk = 1'b0;
  logic       Rst, Load, Abort;
  logic [7:0] Din;
  logic [2:0] rdy, b, vld, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model: slot position 0 = idle, 1..W+G = cycle within the slot
  int         m_pos [3];
  logic [7:0] m_word [3];

  always #5 Clk = ~Clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(1)) d0 (
    .Clk(Clk), .Rst(Rst), .Din(Din), .Load(Load), .Abort(Abort),
    .Ready(rdy[0]), .B(b[0]), .Bit_Vld(vld[0]), .Busy(busy[0]), .Done(done[0]));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(1)) d1 (
    .Clk(Clk), .Rst(Rst), .Din(Din), .Load(Load), .Abort(Abort),
    .Ready(rdy[1]), .B(b[1]), .Bit_Vld(vld[1]), .Busy(busy[1]), .Done(done[1]));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) d2 (
    .Clk(Clk), .Rst(Rst), .Din(Din), .Load(Load), .Abort(Abort),
    .Ready(rdy[2]), .B(b[2]), .Bit_Vld(vld[2]), .Busy(busy[2]), .Done(done[2]));

  function automatic logic m_ready(int k);
    return (m_pos[k] == 0) || (m_pos[k] == W + GP[k]);
  endfunction

  // expected {Ready, B, Bit_Vld, Busy, Done}
  function automatic logic [4:0] m_expect(int k);
    int p;
    logic bit_v;
    p = m_pos[k];
    if (p == 0) return 5'b10000;
    if (p <= W) begin
      bit_v = (MF[k] != 0) ? m_word[k][W - p] : m_word[k][p - 1];
      return {m_ready(k), bit_v, 1'b1, 1'b1, (p == W)};
    end
    return {m_ready(k), 1'b0, 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [4:0] dut_out(int k);
    return {rdy[k], b[k], vld[k], busy[k], done[k]};
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, got, want);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (Rst || Abort) begin
        m_pos[k] = 0;
      end else if (Load && m_ready(k)) begin
        m_pos[k]  = 1;
        m_word[k] = Din;
      end else if (m_pos[k] != 0) begin
        m_pos[k] = (m_pos[k] == W + GP[k]) ? 0 : m_pos[k] + 1;
      end
    end
  endtask

  // one clock: model advances on the edge, outputs are checked on the falling edge
  task automatic step();
    @(posedge Clk);
    model_update();
    @(negedge Clk);
    cyc++;
    for (int k = 0; k < 3; k++) chk("model", k, 32'(dut_out(k)), 32'(m_expect(k)));
  endtask

  typedef struct {
    logic       load;
    logic [7:0] din;
    logic [4:0] e0;
    logic [4:0] e1;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0]  seq0, seq1, cap0, cap1;
    logic [15:0] stream, vmask, dmask, rmask;
    logic        any_b, done_seen;

    // B4 serialized MSB-first and LSB-first, in output order
    seq0 = 8'b10110100;
    seq1 = 8'b00101101;
    for (int i = 0; i < 8; i++) begin
      tbl[i].load = (i == 0);
      tbl[i].din  = (i == 0) ? 8'hB4 : 8'h00;
      tbl[i].e0   = {1'b0, seq0[7 - i], 1'b1, 1'b1, (i == 7)};
      tbl[i].e1   = {1'b0, seq1[7 - i], 1'b1, 1'b1, (i == 7)};
    end
    tbl[8] = '{load: 1'b0, din: 8'h00, e0: 5'b10010, e1: 5'b10010};
    tbl[9] = '{load: 1'b0, din: 8'h00, e0: 5'b10000, e1: 5'b10000};

    for (int k = 0; k < 3; k++) begin
      m_pos[k]  = 0;
      m_word[k] = 8'h00;
    end

    Rst = 1'b1; Load = 1'b0; Abort = 1'b0; Din = 8'h00;
    step();
    step();
    for (int k = 0; k < 3; k++) chk("reset", k, 32'(dut_out(k)), 32'h10);
    Rst = 1'b0;
    step();

    // vector table: B4 word on MSB-first and LSB-first instances
    for (int i = 0; i < 10; i++) begin
      Load = tbl[i].load;
      Din  = tbl[i].din;
      step();
      chk("tbl_msb", 0, 32'(dut_out(0)), 32'(tbl[i].e0));
      chk("tbl_lsb", 1, 32'(dut_out(1)), 32'(tbl[i].e1));
    end

    // GAP=0 back-to-back with Load held high
    stream = '0; vmask = '0; dmask = '0; rmask = '0;
    for (int c = 1; c <= 16; c++) begin
      Load = (c <= 9);
      Din  = (c == 1) ? 8'h06 : 8'h05;
      step();
      stream = {stream[14:0], b[2]};
      vmask  = {vmask[14:0], vld[2]};
      dmask  = {dmask[14:0], done[2]};
      rmask  = {rmask[14:0], rdy[2]};
    end
    chk("b2b_stream", 2, 32'(stream), 32'h0605);
    chk("b2b_valid", 2, 32'(vmask), 32'hFFFF);
    chk("b2b_done", 2, 32'(dmask), 32'h0101);
    chk("b2b_ready", 2, 32'(rmask), 32'h0101);
    Load = 1'b0;
    step();
    chk("b2b_idle", 2, 32'(busy[2]), 32'h0);
    step();
    step();

    // Load while not ready is ignored
    any_b = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      Load = (c == 1) || (c == 5);
      Din  = (c == 5) ? 8'hFF : 8'h00;
      step();
      if (c <= 8) any_b = any_b | b[0];
    end
    chk("ign_b", 0, 32'(any_b), 32'h0);
    chk("ign_busy", 0, 32'(busy[0]), 32'h0);

    // Abort in cycle 3, then Load+Abort while idle
    done_seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      Load  = (c == 1) || (c == 5);
      Abort = (c == 4) || (c == 5);
      Din   = (c == 5) ? 8'hAA : 8'hFF;
      step();
      done_seen = done_seen | done[0];
      if (c == 4 || c == 5)
        for (int k = 0; k < 3; k++) chk("abort", k, 32'(dut_out(k)), 32'h10);
    end
    Abort = 1'b0;
    chk("abort_done", 0, 32'(done_seen), 32'h0);

    // Rst in cycle 5 of a word, then a clean A5 word
    cap0 = '0; cap1 = '0;
    for (int c = 1; c <= 16; c++) begin
      Rst  = (c == 6);
      Load = (c == 1) || (c == 7);
      Din  = (c == 7) ? 8'hA5 : 8'h3C;
      step();
      if (c == 6)
        for (int k = 0; k < 3; k++) chk("rst_mid", k, 32'(dut_out(k)), 32'h10);
      if (c >= 7 && c <= 14) begin
        cap0 = {cap0[6:0], b[0]};
        cap1 = {cap1[6:0], b[1]};
      end
    end
    chk("rst_a5_msb", 0, 32'(cap0), 32'hA5);
    chk("rst_a5_lsb", 1, 32'(cap1), 32'hA5);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      Load  = 1'($urandom_range(0, 1));
      Din   = 8'($urandom);
      Abort = ($urandom_range(0, 15) == 0);
      Rst   = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end for the serial sequence detector stage.
- Accepts a WIDTH-bit word through a Load/Ready handshake and shifts it out one bit per Clk on B, which drives the detector's B input directly.
- Between words it holds B at 0, which is the detector's idle level, for GAP cycles.
- Reports framing with Bit_Vld, Busy and Done.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 shifts Din[WIDTH-1] first; 0 shifts Din[0] first.
- GAP, 1, idle cycles inserted after each word's last bit; legal range 0..15.

Ports:
- Clk  input  1  system clock; all logic on posedge.
- Rst  input  1  synchronous, active-high reset.
- Din  input  WIDTH  parallel word; sampled only on an accepted Load.
- Load  input  1  word valid; accepted on the posedge where Load=1 and Ready=1.
- Abort  input  1  synchronous cancel of the word in flight.
- Ready  output  1  block can accept a word this cycle.
- B  output  1  serial bit stream; feeds the detector's B input.
- Bit_Vld  output  1  B carries a data bit this cycle.
- Busy  output  1  a word slot (bits plus gap) is in progress.
- Done  output  1  one-cycle pulse coincident with the last bit of a word.

Behaviour:
- Clock and reset: one clock, Clk; Rst is synchronous and active-high.
- Reset values: after a posedge with Rst=1, State=IDLE, B=0, Bit_Vld=0, Busy=0, Done=0, Ready=1, shift register and counters cleared.
- Priority: Rst over Abort, Abort over Load.
- Outputs are registered. A slot is WIDTH+GAP cycles long.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Outputs: Ready=1, B=0, Bit_Vld=0, Busy=0.
  - On Load=1, Din is captured into the shift register and State goes to SHIFT.
  - In the next cycle B = first bit, Bit_Vld=1, Busy=1, Ready=0. Latency is 1 cycle from the accept edge to the first bit.
- SHIFT:
  - One bit per cycle in the order set by MSB_FIRST; bit counter runs 0..WIDTH-1.
  - On the last bit: Done=1.
    - If GAP=0, Ready=1 in this same cycle.
    - If GAP>0, next state is GAP.
    - If GAP=0 and no Load, next state is IDLE.
- GAP:
  - Outputs: B=0, Bit_Vld=0, Busy=1, Done=0.
  - Lasts GAP cycles. Ready=1 only in the final GAP cycle; then next state is IDLE.
- Back-to-back: a Load accepted in the final slot cycle (last bit if GAP=0, last gap cycle otherwise) starts the next word's first bit in the following cycle.
  - Consecutive first bits are therefore exactly WIDTH+GAP cycles apart, and there is no IDLE cycle in between.
- Load while Ready=0: ignored; Din is not sampled and no state change occurs. Din changes after acceptance do not affect the word in flight.
- Abort=1 while Busy=1:
  - Next cycle: State=IDLE, B=0, Bit_Vld=0, Busy=0, Done=0, Ready=1.
  - The remaining bits are discarded and no Done is issued.
  - A Load in the same cycle is ignored.
- Abort while IDLE: no effect, but a simultaneous Load is still ignored.
- Rst mid-word: same visible result as Abort, plus counters cleared.
- Counters: bit counter is $clog2(WIDTH) bits, gap counter is 4 bits. Neither may wrap; both reload on each accepted Load.
- B is never X after the first reset edge. B=0 whenever Bit_Vld=0.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=1, GAP=1, Din=8'hB4 loaded at edge E0:
  - B = 1,0,1,1,0,1,0,0 in cycles 1..8 with Bit_Vld=1.
  - Done=1 only in cycle 8.
  - Cycle 9: B=0, Bit_Vld=0, Ready=1.
  - Cycle 10: IDLE with Busy=0.
- MSB_FIRST=0, Din=8'hB4: B = 0,0,1,0,1,1,0,1 in cycles 1..8.
- GAP=0, Load held high with Din=8'h06 then 8'h05:
  - 16 contiguous Bit_Vld cycles.
  - Done in cycles 8 and 16.
  - Ready=1 only in cycles 8 and 16.
  - Downstream detector sees 00000110_00000101 with no idle bit.
- Load pulsed in cycle 4 with Din=8'hFF during an 8'h00 word: ignored. B stays 0 through cycle 8 and no second word starts.
- Abort asserted in cycle 3 of Din=8'hFF:
  - Cycle 4: B=0, Bit_Vld=0, Busy=0, Ready=1, Done never pulses.
  - Load+Abort in the same IDLE cycle: no word starts.
- Rst asserted in cycle 5 of a word, then released:
  - All outputs at reset values.
  - A new Load of 8'hA5 serializes cleanly as 1,0,1,0,0,1,0,1.
